// File: rtl/sram_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_pkg
// Shared definitions for the SRAM-like request arbiter:
//   - source IDs stored in the in-order response FIFO
//   - arbiter FSM state encoding
//   - SRAM transfer size encodings
//   - packed request-field bundle used to mux a master onto the slave port
// ---------------------------------------------------------------------------
package sram_req_arbiter_pkg;

  // Source ID recorded for every accepted address phase
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  // Transfer size encodings on the size fields
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_HOLD_I = 2'd1,
    ST_HOLD_D = 2'd2
  } arb_state_t;

  // All request fields that travel with a request, bundled so a single
  // mux selects the whole address phase of one master.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  // HOLD state that locks the grant onto the given source
  function automatic arb_state_t hold_state(input logic src);
    return (src == SRC_DATA) ? ST_HOLD_D : ST_HOLD_I;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_id_fifo.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_id_fifo
// In-order FIFO of 1-bit source IDs, one entry per accepted request that is
// still waiting for its data_ok.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   push, din         write one source ID
//   pop               retire the head entry
//   full              registered: DEPTH entries held
//   empty             no entries held
//   head              source ID of the oldest entry
// ---------------------------------------------------------------------------
module sram_req_arbiter_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  // A push while full is only legal when the head leaves the same cycle,
  // in which case the slot being freed is the one being written.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_ONE;
    end
  end

  // full is registered so that a pop never re-opens issue in its own cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
      full  <= (count_next == CNT_FULL);
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
// Shares one SRAM-like slave port between the IF-stage instruction master
// (inst_*) and the MEM-stage data master (data_*). The address phase is
// arbitrated with data priority and the grant is held until addr_ok; each
// accepted request's source is queued so the in-order s_data_ok can be
// steered back to the master that issued it.
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   inst_req/wr/size/wstrb/addr/wdata instruction master request
//   inst_addr_ok/data_ok/rdata        instruction master handshake/response
//   data_req/wr/size/wstrb/addr/wdata data master request
//   data_addr_ok/data_ok/rdata        data master handshake/response
//   s_req/wr/size/wstrb/addr/wdata    slave request
//   s_addr_ok, s_data_ok, s_rdata     slave handshake/response
//   proto_err                         sticky: response arrived with no
//                                     request outstanding
// ---------------------------------------------------------------------------
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,

  output logic        proto_err
);

  arb_state_t state;
  logic       active;
  logic       sel_src;
  logic       sel_req;
  logic       issue;
  logic       push;
  logic       rsp_valid;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_head;
  sram_req_t  inst_fields;
  sram_req_t  data_fields;
  sram_req_t  sel_fields;

  // active is low while in reset and for the first cycle after it, keeping
  // every handshake output quiet over that window.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      active <= 1'b0;
    end else begin
      active <= 1'b1;
    end
  end

  // Grant selection: data wins in ARB, a HOLD state locks onto one master.
  always_comb begin
    sel_src = SRC_INST;
    sel_req = 1'b0;
    case (state)
      ST_HOLD_I: begin
        sel_src = SRC_INST;
        sel_req = inst_req;
      end
      ST_HOLD_D: begin
        sel_src = SRC_DATA;
        sel_req = data_req;
      end
      default: begin
        sel_src = data_req ? SRC_DATA : SRC_INST;
        sel_req = inst_req | data_req;
      end
    endcase
  end

  assign inst_fields = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                         addr: inst_addr, wdata: inst_wdata};
  assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                         addr: data_addr, wdata: data_wdata};
  assign sel_fields  = (sel_src == SRC_DATA) ? data_fields : inst_fields;

  assign issue   = sel_req & ~fifo_full & active & resetn;
  assign push    = issue & s_addr_ok;

  assign s_req   = issue;
  assign s_wr    = sel_fields.wr;
  assign s_size  = sel_fields.size;
  assign s_wstrb = sel_fields.wstrb;
  assign s_addr  = sel_fields.addr;
  assign s_wdata = sel_fields.wdata;

  assign inst_addr_ok = push & (sel_src == SRC_INST);
  assign data_addr_ok = push & (sel_src == SRC_DATA);

  // Responses are retired in order; a response with nothing queued is
  // dropped here and flagged through proto_err instead.
  assign rsp_valid    = s_data_ok & active & resetn;
  assign pop          = rsp_valid & ~fifo_empty;
  assign inst_data_ok = pop & (fifo_head == SRC_INST);
  assign data_data_ok = pop & (fifo_head == SRC_DATA);
  assign inst_rdata   = s_rdata;
  assign data_rdata   = s_rdata;

  sram_req_arbiter_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (sel_src),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // Arbiter FSM: a presented but unaccepted request locks the grant until
  // it is accepted or its master withdraws it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_ARB;
    end else begin
      case (state)
        ST_ARB: begin
          if (issue && !s_addr_ok) begin
            state <= hold_state(sel_src);
          end
        end
        default: begin
          if (push || !sel_req) begin
            state <= ST_ARB;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      proto_err <= 1'b0;
    end else if (rsp_valid && fifo_empty) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter
// Self-checking bench for sram_req_arbiter (MAX_OUTST = 2). Directed
// scenarios are followed by randomized traffic; every cycle is checked
// against a reference model built from a queue of outstanding sources.
// ---------------------------------------------------------------------------
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        proto_err;

  always #5 clk = ~clk;

  sram_req_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .s_req        (s_req),
    .s_wr         (s_wr),
    .s_size       (s_size),
    .s_wstrb      (s_wstrb),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_addr_ok    (s_addr_ok),
    .s_data_ok    (s_data_ok),
    .s_rdata      (s_rdata),
    .proto_err    (proto_err)
  );

  typedef struct {
    logic        rst_n;
    logic        ireq, iwr;
    logic [1:0]  isize;
    logic [3:0]  istrb;
    logic [31:0] iaddr, iwdata;
    logic        dreq, dwr;
    logic [1:0]  dsize;
    logic [3:0]  dstrb;
    logic [31:0] daddr, dwdata;
    logic        aok, dok;
    logic [31:0] rdata;
  } stim_t;

  // Reference model: sources waiting for a response, the master whose
  // request was shown but not yet taken (-1 none, 0 inst, 1 data),
  // whether the quiet window after reset has passed, and the error flag.
  bit q[$];
  int pending   = -1;
  bit m_active  = 1'b0;
  bit m_perr    = 1'b0;
  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [1:0] randSize();
    case ($urandom_range(0, 2))
      0:       return SIZE_BYTE;
      1:       return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.rst_n = 1'b1;
    s.ireq = 1'b0; s.iwr = 1'b0; s.isize = SIZE_WORD; s.istrb = 4'hf;
    s.iaddr = 32'h1c00_0000; s.iwdata = 32'h0;
    s.dreq = 1'b0; s.dwr = 1'b0; s.dsize = SIZE_WORD; s.dstrb = 4'hf;
    s.daddr = 32'h8000_0100; s.dwdata = 32'h0;
    s.aok = 1'b0; s.dok = 1'b0; s.rdata = $urandom;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s = idleStim();
    s.ireq   = ($urandom_range(0, 99) < 55);
    s.iwr    = $urandom_range(0, 1);
    s.isize  = randSize();
    s.istrb  = 4'($urandom);
    s.iaddr  = $urandom;
    s.iwdata = $urandom;
    s.dreq   = ($urandom_range(0, 99) < 45);
    s.dwr    = $urandom_range(0, 1);
    s.dsize  = randSize();
    s.dstrb  = 4'($urandom);
    s.daddr  = $urandom;
    s.dwdata = $urandom;
    s.aok    = ($urandom_range(0, 99) < 60);
    s.dok    = (q.size() > 0) && ($urandom_range(0, 99) < 45);
    return s;
  endfunction

  // One clock cycle: drive on the falling edge, check 1ns later, then
  // advance the model on the rising edge.
  task automatic applyStimulus(input stim_t s);
    bit          en, cand, creq, exp_req, has_head;
    logic [31:0] exp_addr, exp_wdata, exp_ctl;
    @(negedge clk);
    resetn = s.rst_n;
    inst_req = s.ireq; inst_wr = s.iwr; inst_size = s.isize;
    inst_wstrb = s.istrb; inst_addr = s.iaddr; inst_wdata = s.iwdata;
    data_req = s.dreq; data_wr = s.dwr; data_size = s.dsize;
    data_wstrb = s.dstrb; data_addr = s.daddr; data_wdata = s.dwdata;
    s_addr_ok = s.aok; s_data_ok = s.dok; s_rdata = s.rdata;
    #1;
    en = s.rst_n && m_active;
    if (pending >= 0) begin
      cand = (pending == 1);
      creq = cand ? s.dreq : s.ireq;
    end else begin
      cand = s.dreq;
      creq = s.ireq | s.dreq;
    end
    exp_req  = en && creq && (q.size() < MAX_OUTST);
    has_head = en && s.dok && (q.size() > 0);
    checkOutput("s_req", 32'(s_req), 32'(exp_req));
    checkOutput("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_req && s.aok && !cand));
    checkOutput("data_addr_ok", 32'(data_addr_ok), 32'(exp_req && s.aok && cand));
    checkOutput("inst_data_ok", 32'(inst_data_ok), 32'(has_head && q[0] == 1'b0));
    checkOutput("data_data_ok", 32'(data_data_ok), 32'(has_head && q[0] == 1'b1));
    checkOutput("proto_err", 32'(proto_err), 32'(m_perr));
    checkOutput("inst_rdata", inst_rdata, s.rdata);
    checkOutput("data_rdata", data_rdata, s.rdata);
    if (exp_req) begin
      exp_addr  = cand ? s.daddr : s.iaddr;
      exp_wdata = cand ? s.dwdata : s.iwdata;
      exp_ctl   = cand ? {25'd0, s.dwr, s.dsize, s.dstrb}
                       : {25'd0, s.iwr, s.isize, s.istrb};
      checkOutput("s_addr", s_addr, exp_addr);
      checkOutput("s_wdata", s_wdata, exp_wdata);
      checkOutput("s_wr_size_wstrb", {25'd0, s_wr, s_size, s_wstrb}, exp_ctl);
    end
    @(posedge clk);
    if (!s.rst_n) begin
      q.delete();
      pending  = -1;
      m_active = 1'b0;
      m_perr   = 1'b0;
    end else begin
      if (en && s.dok) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_perr = 1'b1;
      end
      if (exp_req && s.aok) q.push_back(cand);
      pending  = (exp_req && !s.aok) ? (cand ? 1 : 0) : -1;
      m_active = 1'b1;
    end
  endtask

  initial begin
    stim_t s;

    // Reset with traffic present, then the quiet cycle after reset
    for (int i = 0; i < 2; i++) begin
      s = randStim(); s.rst_n = 1'b0; s.ireq = 1'b1; s.aok = 1'b1;
      applyStimulus(s);
    end
    s = idleStim(); s.ireq = 1'b1; s.dreq = 1'b1; s.aok = 1'b1;
    applyStimulus(s);

    // Single instruction read, response two cycles after acceptance
    s = idleStim(); s.ireq = 1'b1; s.iaddr = 32'h1c00_0000; s.aok = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());
    s = idleStim(); s.dok = 1'b1; s.rdata = 32'h1234_5678;
    applyStimulus(s);

    // Simultaneous requests: data first, instruction next cycle
    s = idleStim(); s.ireq = 1'b1; s.dreq = 1'b1; s.aok = 1'b1;
    applyStimulus(s);
    s = idleStim(); s.ireq = 1'b1; s.aok = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 2; i++) begin
      s = idleStim(); s.dok = 1'b1;
      applyStimulus(s);
    end

    // Data request stalled three cycles while instruction request arrives
    for (int i = 0; i < 3; i++) begin
      s = idleStim(); s.dreq = 1'b1; s.dwr = 1'b1; s.ireq = (i > 0);
      applyStimulus(s);
    end
    s = idleStim(); s.dreq = 1'b1; s.dwr = 1'b1; s.ireq = 1'b1; s.aok = 1'b1;
    applyStimulus(s);
    s = idleStim(); s.ireq = 1'b1; s.aok = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 2; i++) begin
      s = idleStim(); s.dok = 1'b1;
      applyStimulus(s);
    end

    // inst, data, inst with responses withheld: third waits for a pop
    s = idleStim(); s.ireq = 1'b1; s.aok = 1'b1; applyStimulus(s);
    s = idleStim(); s.dreq = 1'b1; s.aok = 1'b1; applyStimulus(s);
    s = idleStim(); s.ireq = 1'b1; s.iaddr = 32'h1c00_0040; s.aok = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s.dok = 1'b1; applyStimulus(s);
    s.dok = 1'b0; applyStimulus(s);
    for (int i = 0; i < 2; i++) begin
      s = idleStim(); s.dok = 1'b1;
      applyStimulus(s);
    end

    // Stray response with nothing outstanding sets the sticky error
    s = idleStim(); s.dok = 1'b1; applyStimulus(s);
    for (int i = 0; i < 3; i++) applyStimulus(randStim());

    // Reset with two data requests outstanding, then a fresh inst read
    s = idleStim(); s.dreq = 1'b1; s.aok = 1'b1; applyStimulus(s);
    s = idleStim(); s.dreq = 1'b1; s.aok = 1'b1; applyStimulus(s);
    s = idleStim(); s.rst_n = 1'b0; applyStimulus(s);
    applyStimulus(idleStim());
    s = idleStim(); s.ireq = 1'b1; s.aok = 1'b1; applyStimulus(s);
    s = idleStim(); s.dok = 1'b1; applyStimulus(s);
    s = idleStim(); s.dok = 1'b1; applyStimulus(s);
    applyStimulus(idleStim());

    // Randomized traffic
    for (int i = 0; i < 400; i++) applyStimulus(randStim());

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
